// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch stage and the main control decoder.
// PCOp values, primary opcodes and fetch FSM state codes.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BEQ = 2'b01;
    localparam logic [1:0] PC_BNE = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, beq/bne, j and jr.
// All arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic [1:0]        pc_op,
    input  logic              is_jr,
    input  logic              zero,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] jmp_pc;
    logic              unused_opcode;

    assign seq_pc = pc + ADDR_W'(4);
    assign br_off = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign br_pc  = seq_pc + br_off;
    // Jump keeps the region bits of the delay-slot-free pc+4.
    assign jmp_pc = {seq_pc[ADDR_W-1:28], instr[25:0], 2'b00};
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = seq_pc;
        if (is_jr) begin
            next_pc = {jr_target[ADDR_W-1:2], 2'b00};
        end else begin
            case (pc_op)
                PC_SEQ:  next_pc = seq_pc;
                PC_BEQ:  next_pc = zero ? br_pc : seq_pc;
                PC_BNE:  next_pc = zero ? seq_pc : br_pc;
                PC_JMP:  next_pc = jmp_pc;
                default: next_pc = seq_pc;
            endcase
        end
    end

    assign misalign = is_jr & (|jr_target[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack toward imem, valid/ready toward the datapath,
// next-PC selection on acceptance.
//   state | meaning
//   IDLE  | no request; leave when halt is low
//   REQ   | imem_req high at pc; wait for imem_ack
//   HOLD  | instr_valid high; wait for instr_ready, then update pc
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [1:0]        pc_op,
    input  logic              is_jr,
    input  logic              zero,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              halt,
    output logic              align_err
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              align_q, align_d;
    logic [ADDR_W-1:0] next_pc;
    logic              misalign;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc        (pc_q),
        .instr     (instr_q),
        .pc_op     (pc_op),
        .is_jr     (is_jr),
        .zero      (zero),
        .jr_target (jr_target),
        .next_pc   (next_pc),
        .misalign  (misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        align_d = align_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    align_d = align_q | misalign;
                    state_d = halt ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            align_q <= align_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = valid_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign align_err   = align_q;

endmodule
